// File: rtl/writeback_arbiter_if.sv
// Bundle of the writeback producer/consumer signals: ALU and load result
// inputs with their ready handshakes, and the register-file write outputs.
interface writeback_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int RW = $clog2(NREGS);

    // Valid/ready: a result transfers on any rising edge where valid and ready
    // are both high. Ready never depends on valid in the same cycle.
    logic             alu_valid;
    logic [RW-1:0]    alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             alu_ready;

    logic             ld_valid;
    logic [RW-1:0]    ld_rd;
    logic [XLEN-1:0]  ld_data;
    logic             ld_ready;

    logic [NREGS-1:0] wr_en;
    logic [XLEN-1:0]  wr_data;
    logic [7:0]       wb_error;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        input  wr_en, wr_data, wb_error
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        output wr_en, wr_data, wb_error
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges ALU and buffered load results into one registered register write per
// cycle, with an age counter so a waiting load cannot be starved by the ALU.
module writeback_arbiter #(
    parameter int XLEN          = 32,
    parameter int NREGS         = 32,
    parameter int LD_FIFO_DEPTH = 4,
    parameter int AGE_LIMIT     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    writeback_arbiter_if.slave  bus
);
    localparam int RW = $clog2(NREGS);
    localparam int PW = $clog2(LD_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(AGE_LIMIT + 1);
    localparam logic [CW-1:0]    FULL_CNT = CW'(LD_FIFO_DEPTH);
    localparam logic [AW-1:0]    AGE_MAX  = AW'(AGE_LIMIT);
    localparam logic [NREGS-1:0] ONE_HOT0 = NREGS'(1);

    logic [RW-1:0]   r_fifo_rd   [LD_FIFO_DEPTH];
    logic [XLEN-1:0] r_fifo_data [LD_FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_age;

    logic [NREGS-1:0] r_wr_en;
    logic [XLEN-1:0]  r_wr_data;
    logic [3:0]       r_err;

    logic            w_empty;
    logic            w_full;
    logic            w_fifo_wins;
    logic            w_push;
    logic            w_pop;
    logic            w_sel_valid;
    logic [RW-1:0]   w_sel_rd;
    logic [XLEN-1:0] w_sel_data;
    logic [RW-1:0]   w_head_rd;
    logic [XLEN-1:0] w_head_data;
    logic            w_collision;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_CNT);
    assign w_head_rd   = r_fifo_rd[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // Forced FIFO win depends on registered state only, so alu_ready is stable
    // for the whole cycle regardless of what the ALU presents.
    assign w_fifo_wins = !w_empty && (w_full || (r_age >= AGE_MAX));

    assign bus.alu_ready = !w_fifo_wins;
    assign bus.ld_ready  = !w_full;

    // A full FIFO refuses the push even if it also pops this cycle.
    assign w_push = bus.ld_valid && !w_full;

    always_comb begin
        w_pop       = 1'b0;
        w_sel_valid = 1'b0;
        w_sel_rd    = '0;
        w_sel_data  = '0;
        if (w_fifo_wins) begin
            w_pop       = 1'b1;
            w_sel_valid = 1'b1;
            w_sel_rd    = w_head_rd;
            w_sel_data  = w_head_data;
        end else if (bus.alu_valid) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = bus.alu_rd;
            w_sel_data  = bus.alu_data;
        end else if (!w_empty) begin
            w_pop       = 1'b1;
            w_sel_valid = 1'b1;
            w_sel_rd    = w_head_rd;
            w_sel_data  = w_head_data;
        end
    end

    assign w_collision = bus.alu_valid && !w_empty &&
                         (bus.alu_rd == w_head_rd) && (bus.alu_rd != '0);

    // Entry storage carries no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= bus.ld_rd;
            r_fifo_data[r_wr_ptr] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_age <= '0;
        end else if (w_pop || w_empty) begin
            r_age <= '0;
        end else if (r_age != AGE_MAX) begin
            r_age <= r_age + 1'b1;
        end
    end

    // Writes to register 0 are consumed silently and leave wr_data untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= '0;
            r_wr_data <= '0;
        end else if (w_sel_valid && (w_sel_rd != '0)) begin
            r_wr_en   <= ONE_HOT0 << w_sel_rd;
            r_wr_data <= w_sel_data;
        end else begin
            r_wr_en   <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= '0;
        end else begin
            if (w_sel_valid && (w_sel_rd == '0)) begin
                r_err[0] <= 1'b1;
            end
            if (w_fifo_wins && !w_full) begin
                r_err[1] <= 1'b1;
            end
            if (w_collision) begin
                r_err[2] <= 1'b1;
            end
            if (bus.ld_valid && w_full) begin
                r_err[3] <= 1'b1;
            end
        end
    end

    assign bus.wr_en    = r_wr_en;
    assign bus.wr_data  = r_wr_data;
    assign bus.wb_error = {4'b0000, r_err};
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writeback stage directly upstream of the architectural register storage. It merges ALU results and load results into a single register write per cycle. Load results are buffered in a small FIFO and arbitrated against ALU results with an anti-starvation age counter. The block produces a registered one-hot per-register write enable plus write data, and keeps a sticky error/status vector.

## Interface
- XLEN, 32, data width of results and write data
- NREGS, 32, number of architectural registers; rd index width is $clog2(NREGS)
- LD_FIFO_DEPTH, 4, load-result FIFO entries (power of 2, ≥2)
- AGE_LIMIT, 8, cycles a non-empty FIFO head may wait before it wins arbitration
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present
- alu_rd  in  $clog2(NREGS)  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU result accepted this cycle when alu_valid && alu_ready
- ld_valid  in  1  load result present
- ld_rd  in  $clog2(NREGS)  load destination register
- ld_data  in  XLEN  load result
- ld_ready  out  1  FIFO push accepted when ld_valid && ld_ready
- wr_en  out  NREGS  registered one-hot write enable, bit i drives register i
- wr_data  out  XLEN  registered write data, common to all registers
- wb_error  out  8  sticky status flags, cleared only by reset

## Operation
- Load FIFO: circular buffer with read/write pointers and count. Push on ld_valid && ld_ready. ld_ready = (count != LD_FIFO_DEPTH). No push when full, even if a pop occurs in the same cycle.
- Arbitration each cycle: at most one write is selected.
  - fifo_wins = (count != 0) && ((count == LD_FIFO_DEPTH) || (age >= AGE_LIMIT)).
  - alu_ready = !fifo_wins. This is a function of registered state only, never of alu_valid.
  - If fifo_wins: pop the FIFO head and write it.
  - Else if alu_valid: write the ALU result.
  - Else if count != 0: pop the FIFO head and write it (idle slot used).
  - Else: no write.
- Age counter: resets to 0 on any pop or when the FIFO is empty. Otherwise increments each cycle the head stays, saturating at AGE_LIMIT.
- Write generation: a selected result with rd != 0 sets wr_en = 1 << rd and wr_data = data on the next edge. A result with rd == 0 is consumed with wr_en = 0, and wr_data holds its previous value. With no write selected, wr_en = 0 and wr_data holds.
- wb_error bits, set and sticky:
  - [0] rd == 0 write discarded
  - [1] age-limit arbitration fired (fifo_wins with count < LD_FIFO_DEPTH)
  - [2] same-cycle collision: alu_valid and FIFO head non-empty with equal non-zero rd
  - [3] ld_valid while FIFO full
  - [7:4] reserved, always 0
- Ordering: writes appear in arbitration order. No reordering within the load stream; load FIFO order is preserved.

## Timing
- Reset (rst_n low, asynchronous): wr_en = 0, wr_data = 0, wb_error = 0, FIFO empty, age = 0. Hence ld_ready = 1 and alu_ready = 1 while in reset and after release.
- ALU latency: accepted at edge N → wr_en/wr_data valid during cycle N+1, for one cycle.
- Load latency: pushed at edge N → earliest pop at edge N+1 → write visible in cycle N+2.
- Throughput: one write per cycle. The FIFO sustains one push plus one pop per cycle when not full.
- Reset asserted mid-operation discards FIFO contents and any pending write immediately. No partial write survives.
- Pointer wrap: pointers wrap modulo LD_FIFO_DEPTH. Full/empty are distinguished by count, not by pointer equality.

## Test plan
- Reset, then ALU alu_rd=5, alu_data=0xDEADBEEF for one cycle → next cycle wr_en=0x00000020, wr_data=0xDEADBEEF, then wr_en=0.
- Idle ALU, load ld_rd=3, data=0x11 → wr_en=0x8, wr_data=0x11 two cycles after the push.
- Continuous alu_valid plus 4 loads pushed: FIFO fills, alu_ready drops while count==4, then FIFO entries drain in order, ld_ready=0 while full. Additional ld_valid while full sets wb_error[3].
- Continuous alu_valid plus a single load: the load is written after the head waits AGE_LIMIT=8 cycles. alu_ready is 0 for exactly that one arbitration cycle, and wb_error[1]=1.
- ALU rd=0 with data 0x55 → wr_en stays 0, wr_data unchanged, wb_error[0]=1. ALU rd=7 with FIFO head rd=7 in the same cycle → wb_error[2]=1, ALU written first.
- Assert rst_n low with 3 FIFO entries pending → outputs 0 immediately, no load writes after release, ld_ready=1.
